// File: rtl/sr_flag_pkg.sv
// sr_flag_pkg: shared command encodings, FSM states and sizing helper for the SR flag arbiter
package sr_flag_pkg;
  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;
  typedef enum logic {ST_IDLE, ST_APPLY} state_t;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sr_flag_cell.sv
// sr_flag_cell: synchronous SR flag cell; a set+reset holds under SR_FLAG_CONFLICT_DETECT_EN, else resets
module sr_flag_cell
  import sr_flag_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);
  logic [1:0] w_sr;
  logic       w_both;
  assign w_sr = {s, r};
`ifdef SR_FLAG_CONFLICT_DETECT_EN
  assign w_both = q;
`else
  assign w_both = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) q <= 1'b0;
    else if (en) q <= (w_sr == CMD_SET) ? 1'b1 : (w_sr == CMD_RST) ? 1'b0 : (w_sr == CMD_BOTH) ? w_both : q;
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin sharing of NFLAGS SR flag cells among NREQ requesters
// Optional conflict reporting on a captured set+reset: SR_FLAG_CONFLICT_DETECT_EN
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  localparam int IW    = clog2_min1(NFLAGS),
  localparam int NW    = clog2_min1(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr_all,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      cmd_s,
  input  logic [NREQ-1:0]      cmd_r,
  input  logic [NREQ*IW-1:0]   idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [NFLAGS-1:0]    flags,
  output logic                 err_valid,
  output logic [NW-1:0]        err_id
);
  state_t          r_state;
  logic [NW-1:0]   r_rr, w_win, w_j;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx [NREQ];
  logic [NREQ-1:0] r_gnt;
  logic            r_s, r_r, r_busy, w_found, w_take;
  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_unpack
    assign w_idx[g] = idx[g*IW +: IW];
  end
  // Scan from the highest offset down so the nearest requester at or after r_rr wins
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = NW'((int'(r_rr) + k) % NREQ);
      if (req[w_j]) begin
        w_found = 1'b1;
        w_win   = w_j;
      end
    end
  end
  assign w_take = (r_state == ST_IDLE) && en && w_found;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_rr    <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_idx   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_take) begin
        r_state <= ST_APPLY;
        r_s     <= cmd_s[w_win];
        r_r     <= cmd_r[w_win];
        r_idx   <= w_idx[w_win];
        r_gnt   <= NREQ'(1) << w_win;
        r_busy  <= 1'b1;
        r_rr    <= NW'((int'(w_win) + 1) % NREQ);
      end
    end else begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end
  assign gnt  = r_gnt;
  assign busy = r_busy;
  // clr_all overrides the captured command by forcing a reset into every cell
  for (g = 0; g < NFLAGS; g++) begin : g_cell
    logic w_sel;
    assign w_sel = (r_state == ST_APPLY) && (r_idx == IW'(g));
    sr_flag_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (w_sel | clr_all),
      .s   (w_sel & r_s & ~clr_all),
      .r   (clr_all | (w_sel & r_r)),
      .q   (flags[g])
    );
  end
`ifdef SR_FLAG_CONFLICT_DETECT_EN
  logic [NW-1:0] r_id, r_err_id;
  logic          r_err_valid, w_conf;
  assign w_conf = (r_state == ST_APPLY) && !clr_all && r_s && r_r;
  always_ff @(posedge clk)
    if (rst) begin
      r_id        <= '0;
      r_err_valid <= 1'b0;
      r_err_id    <= '0;
    end else begin
      if (w_take) r_id <= w_win;
      r_err_valid <= w_conf;
      if (w_conf) r_err_id <= r_id;
    end
  assign err_valid = r_err_valid;
  assign err_id    = r_err_id;
`else
  assign err_valid = 1'b0;
  assign err_id    = '0;
`endif
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: directed and randomized checks of sr_flag_arbiter against a behavioural model
module tb_sr_flag_arbiter;
  localparam int N  = 4;
  localparam int NF = 12;
  localparam int IW = 4;
`ifdef SR_FLAG_CONFLICT_DETECT_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            rst, en, clr_all;
  logic [N-1:0]    req, cmd_s, cmd_r;
  logic [N*IW-1:0] idx;
  logic [N-1:0]    gnt;
  logic            busy, err_valid;
  logic [NF-1:0]   flags;
  logic [1:0]      err_id;
  int n_chk = 0, n_fail = 0;
  sr_flag_arbiter #(.NREQ(N), .NFLAGS(NF)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_all(clr_all), .req(req), .cmd_s(cmd_s),
    .cmd_r(cmd_r), .idx(idx), .gnt(gnt), .busy(busy), .flags(flags),
    .err_valid(err_valid), .err_id(err_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Behavioural model: one pending command at most; granted commands land one edge later
  logic [NF-1:0] e_flags;
  logic [N-1:0]  e_gnt;
  bit            e_busy, e_ev, m_pend, m_valid = 1'b0, m_s, m_r;
  int            e_eid, m_ptr, m_idx, m_id;
  always @(posedge clk) begin
    if (rst) begin
      e_flags = '0; e_gnt = '0; e_busy = 0; e_ev = 0; e_eid = 0;
      m_pend = 0; m_ptr = 0; m_s = 0; m_r = 0; m_idx = 0; m_id = 0; m_valid = 1;
    end else if (m_pend) begin
      e_ev = 0;
      if (clr_all) e_flags = '0;
      else if (m_s && m_r && CD) begin
        e_ev = 1;
        e_eid = m_id;
      end else if (m_idx < NF && (m_s || m_r)) e_flags[m_idx] = !m_r;
      e_gnt = '0; e_busy = 0; m_pend = 0;
    end else begin
      int w;
      e_ev = 0;
      w = -1;
      if (clr_all) e_flags = '0;
      if (en) for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_id = w; m_s = cmd_s[w]; m_r = cmd_r[w]; m_idx = int'(idx[w*IW +: IW]);
        e_gnt = N'(1) << w; e_busy = 1; m_ptr = (w + 1) % N; m_pend = 1;
      end
    end
  end
  always @(negedge clk)
    if (m_valid) begin
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, e_busy);
      chk("flags", flags, e_flags);
      chk("err_valid", err_valid, e_ev);
      chk("err_id", err_id, e_eid);
    end
  // mode 1: clr_all in the APPLY cycle; mode 2: rst in the APPLY cycle
  task automatic txn(input int k, input bit s, input bit r, input int i, input int mode);
    req = '0; req[k] = 1'b1; cmd_s[k] = s; cmd_r[k] = r; idx[k*IW +: IW] = IW'(i);
    @(negedge clk);
    chk("txn_gnt", gnt, N'(1) << k);
    chk("txn_busy", busy, 1);
    req[k] = 1'b0;
    clr_all = (mode == 1);
    rst = (mode == 2);
    @(negedge clk);
    clr_all = 1'b0; rst = 1'b0;
    chk("txn_gnt_end", gnt, 0);
    chk("txn_busy_end", busy, 0);
  endtask
  initial begin
    rst = 1; en = 1; clr_all = 0; req = '0; cmd_s = '0; cmd_r = '0; idx = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0); chk("rst_busy", busy, 0); chk("rst_flags", flags, 0);
    chk("rst_err", err_valid, 0); chk("rst_eid", err_id, 0);
    rst = 0;
    txn(0, 1, 0, 3, 0);
    chk("single_set", flags, 12'h008);
    rst = 1; @(negedge clk); rst = 0;
    req = 4'hF; cmd_s = '0; cmd_r = '0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk); chk("rr_gnt", gnt, 1 << i); req[i] = 1'b0;
      @(negedge clk); chk("rr_gap", gnt, 0);
    end
    req = 4'hF;
    @(negedge clk); chk("rr_wrap", gnt, 4'b0001); req = '0;
    @(negedge clk);
    txn(0, 1, 0, 5, 0); chk("set5", flags, 12'h020);
    txn(2, 0, 1, 5, 0); chk("rst5", flags, 12'h000);
    txn(1, 1, 0, 13, 0); chk("oob_idx", flags, 12'h000);
    for (int i = 4; i < 8; i++) txn(i % N, 1, 0, i, 0);
    chk("preload_f0", flags, 12'h0F0);
    txn(0, 1, 0, 1, 1); chk("clr_in_apply", flags, 12'h000);
    txn(0, 1, 0, 2, 0);
    txn(3, 1, 1, 2, 0);
    chk("conf_flags", flags, CD ? 12'h004 : 12'h000);
    chk("conf_err", err_valid, CD);
    chk("conf_eid", err_id, CD ? 3 : 0);
    @(negedge clk); chk("conf_err_pulse", err_valid, 0);
    txn(1, 1, 0, 8, 0); chk("set8", flags, CD ? 12'h104 : 12'h100);
    txn(2, 1, 0, 0, 2); chk("rst_apply_flags", flags, 12'h000);
    en = 0; req = 4'b0001; cmd_s = 4'b0001; cmd_r = '0; idx = '0;
    repeat (3) begin @(negedge clk); chk("en_block", gnt, 0); end
    en = 1;
    @(negedge clk); chk("en_release", gnt, 4'b0001); req = '0;
    @(negedge clk); chk("en_flag", flags, 12'h001);
    repeat (3000) begin
      @(negedge clk);
      for (int k = 0; k < N; k++)
        if (req[k] && gnt[k]) req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k] = 1'b1; cmd_s[k] = 1'($urandom); cmd_r[k] = 1'($urandom);
          idx[k*IW +: IW] = IW'($urandom_range(0, 15));
        end
      en = ($urandom_range(0, 9) != 0);
      clr_all = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 199) == 0);
    end
    rst = 0; clr_all = 0; en = 1; req = '0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shares one bank of NFLAGS set/reset flag cells between NREQ requesters. Each requester issues a set, reset or hold command to one flag index.
- A round-robin arbiter grants one command at a time. The winning command is applied through the flag-cell write enable.
- Sits beside the latch/flip-flop primitives as the controller that sequences and shares them. All cell behaviour is synchronous; there is no level-sensitive storage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAGS, 8, number of flag cells (2..64).
- IW, $clog2(NFLAGS), flag index width. Derived localparam; not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  in  1  global enable; low freezes arbitration.
- clr_all  in  1  clear every flag (highest priority).
- req  in  NREQ  per-requester request, level; held until granted.
- cmd_s  in  NREQ  per-requester set command bit.
- cmd_r  in  NREQ  per-requester reset command bit.
- idx  in  NREQ*IW  per-requester flag index, packed; requester k uses bits [k*IW +: IW].
- gnt  out  NREQ  one-hot grant pulse, one cycle, registered.
- busy  out  1  high in APPLY state.
- flags  out  NFLAGS  current flag values, registered.
- err_valid  out  1  conflict error pulse (see Optional Feature).
- err_id  out  $clog2(NREQ)  requester index of the conflicting command.

Behaviour:
- Reset values: flags=0, gnt=0, busy=0, err_valid=0, err_id=0, state=IDLE, rr_ptr=0, captured command=0.
- State machine, two states:
  - IDLE: if en=1 and |req, select the winner w = first set req bit searching upward from rr_ptr with wrap-around. At the clock edge:
    - capture {cmd_s[w], cmd_r[w], idx[w]};
    - set gnt=onehot(w) and busy=1;
    - set rr_ptr=(w+1) mod NREQ;
    - go to APPLY.
    If en=0 or req=0, stay in IDLE with gnt=0.
  - APPLY: gnt and busy are high for exactly this one cycle. At the edge ending APPLY:
    - apply the captured command to flags[idx];
    - clear gnt and busy;
    - return to IDLE.
- Timing:
  - Request sampled in cycle t; gnt high in cycle t+1; flags change visible in cycle t+2.
  - Maximum throughput is one command per 2 cycles. No arbitration happens in APPLY.
- Requester rule: keep req, cmd and idx stable until gnt is seen, and drop req in the gnt cycle. If req is still high in the following IDLE cycle, it is a new request and competes under the advanced rr_ptr.
- Command decode for the captured {S,R}:
  - 00: hold.
  - 01: flag=0.
  - 10: flag=1.
  - 11: see Optional Feature. The result is never X.
- Index idx >= NFLAGS: command is still consumed (gnt issued); no flag changes.
- clr_all=1 at any edge:
  - all flags are 0 after that edge;
  - in APPLY, the captured command is discarded, but gnt is still pulsed and the FSM returns to IDLE;
  - in IDLE, arbitration proceeds normally.
- en=0 during APPLY: the command still completes; only new grants are blocked.
- rst mid-APPLY: the command is dropped and gnt goes to 0 at that edge. rst has priority over clr_all.

Optional Feature:
- Macro: SR_FLAG_CONFLICT_DETECT_EN.
- Defined: a captured 11 leaves the flag unchanged. err_valid pulses for one cycle, coincident with the flag-update edge, i.e. visible in cycle t+2. err_id holds the granted requester index and keeps that value until the next error.
- Undefined: a captured 11 acts as reset-dominant, so flag=0. err_valid and err_id are tied to 0.

Decomposition:
- Package sr_flag_pkg:
  - cmd encoding constants CMD_HOLD=2'b00, CMD_RST=2'b01, CMD_SET=2'b10, CMD_BOTH=2'b11;
  - state enum {ST_IDLE, ST_APPLY};
  - helper function clog2_min1.
- One sub-module, sr_flag_cell: synchronous SR cell with ports clk, rst, en, s, r, q, using the decode above. It is instantiated NFLAGS times; the flag-update write enable comes from APPLY, and clr_all drives the cell's r input.

Test Plan:
- Reset then single request: req=0001, cmd_s=1, idx0=3 → gnt=0001 in cycle t+1; flags=0x08 in cycle t+2; busy high for exactly one cycle.
- Round-robin: req=1111 held, each requester dropping req after its grant → grants in order 0001, 0010, 0100, 1000, one every 2 cycles; rr_ptr wraps to 0.
- Set then reset: req0 sets idx 5, then req2 resets idx 5 → flags=0x20, then 0x00; an idx=9 request with NFLAGS=8 gets gnt but flags stay unchanged.
- clr_all asserted in the APPLY cycle of a set on idx 1, with flags=0xF0 → gnt still pulses; flags=0x00 afterwards; the set is lost.
- Conflict: cmd_s=cmd_r=1 from req3 on idx 2, with flag 2 = 1:
  - macro defined → flag stays 1, err_valid pulses, err_id=3;
  - macro undefined → flag=0, err_valid=0.
- Reset and enable: rst asserted in APPLY → gnt=0 and flags=0 next cycle; en=0 with req pending → no gnt until en=1.
